dcache_port_arbiter: RTL and testbench

//  Shares the single data-cache port between the memory-read stage (load port) and the

---
 rtl/dcache_port_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter
//
// Shares the single data-cache port between the load port (memory-read stage)
// and the store port (write-back stage). Only one transaction is in flight at
// a time. The arbiter drives the request phase (reqcyc/reqack) and then waits
// for the response phase (respcyc/respack for reads, writeack for writes).
// When both ports request in the same cycle, the grant alternates between
// them. A watchdog aborts a transaction that waits too long for its response.
//
// Ports
//   clk, reset                  core clock, synchronous active-high reset
//   rd_req_valid/addr/ready     load request handshake (ready is comb, IDLE only)
//   rd_resp_valid/data          one-cycle load response pulse, data held
//   wr_req_valid/addr/data/ready store request handshake (ready is comb, IDLE only)
//   wr_done                     one-cycle store completion pulse
//   reqcyc/req/reqdata/reqtag   cache request channel (registered)
//   reqack                      cache accepted the request
//   respcyc/resp/respack        cache read response and its acknowledge
//   writeack                    cache write completion
//   busy                        a transaction is in flight
//   timeout_err                 sticky watchdog-abort flag, cleared by reset
// -----------------------------------------------------------------------------
module dcache_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 13,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req_valid,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_req_ready,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req_valid,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              wr_req_ready,
  output logic              wr_done,
  output logic              reqcyc,
  output logic [ADDR_W-1:0] req,
  output logic [DATA_W-1:0] reqdata,
  output logic [TAG_W-1:0]  reqtag,
  input  logic              reqack,
  input  logic              respcyc,
  input  logic [DATA_W-1:0] resp,
  output logic              respack,
  input  logic              writeack,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } state_t;

  // Tag layout {READ|WRITE, MEMORY, DATA, 7'b0}: READ=1, WRITE=0, MEMORY=4'b0001, DATA=0
  localparam logic [12:0]      TAG_BASE_RD = {1'b1, 4'b0001, 1'b0, 7'b0000000};
  localparam logic [12:0]      TAG_BASE_WR = {1'b0, 4'b0001, 1'b0, 7'b0000000};
  localparam logic [TAG_W-1:0] TAG_RD      = TAG_W'(TAG_BASE_RD);
  localparam logic [TAG_W-1:0] TAG_WR      = TAG_W'(TAG_BASE_WR);

  // One extra bit so TIMEOUT-1 always fits, including power-of-two TIMEOUT
  localparam int                WDOG_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               last_grant_wr_r;  // 0: load port won last, 1: store port won last
  logic [WDOG_W-1:0]  wdog_r;
  logic               grant_rd_s;
  logic               grant_wr_s;
  logic               rd_fire_s;
  logic               wr_fire_s;
  logic               abort_s;
  logic               wdog_clr_s;

  assign rd_req_ready = grant_rd_s;
  assign wr_req_ready = grant_wr_s;
  assign busy         = (state_r != ST_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, grant decision, completion and watchdog-abort decode
  always_comb begin
    state_nxt_s = state_r;
    grant_rd_s  = 1'b0;
    grant_wr_s  = 1'b0;
    respack     = 1'b0;
    rd_fire_s   = 1'b0;
    wr_fire_s   = 1'b0;
    abort_s     = 1'b0;
    wdog_clr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Store wins when alone, or when contested and the load port won last time
        if (wr_req_valid && (!rd_req_valid || !last_grant_wr_r)) begin
          grant_wr_s  = 1'b1;
          state_nxt_s = ST_WR_REQ;
        end else if (rd_req_valid) begin
          grant_rd_s  = 1'b1;
          state_nxt_s = ST_RD_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (reqack) begin
          wdog_clr_s  = 1'b1;
          state_nxt_s = ST_RD_RESP;
        end else begin
          state_nxt_s = ST_RD_REQ;
        end
      end
      ST_RD_RESP: begin
        respack = respcyc;
        // A response on the final watchdog cycle still completes normally
        if (respcyc) begin
          rd_fire_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (wdog_r == WDOG_LAST) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RD_RESP;
        end
      end
      ST_WR_REQ: begin
        // writeack together with reqack finishes the store without a WR_WAIT cycle
        if (reqack && writeack) begin
          wr_fire_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (reqack) begin
          wdog_clr_s  = 1'b1;
          state_nxt_s = ST_WR_WAIT;
        end else begin
          state_nxt_s = ST_WR_REQ;
        end
      end
      ST_WR_WAIT: begin
        if (writeack) begin
          wr_fire_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (wdog_r == WDOG_LAST) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WR_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Remember which port won the most recent grant for contested arbitration
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_wr_r <= 1'b0;
    end else if (grant_wr_s) begin
      last_grant_wr_r <= 1'b1;
    end else if (grant_rd_s) begin
      last_grant_wr_r <= 1'b0;
    end
  end

  // Watchdog: counts cycles spent waiting for a response, restarted on entry
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_r <= {WDOG_W{1'b0}};
    end else if (wdog_clr_s) begin
      wdog_r <= {WDOG_W{1'b0}};
    end else if ((state_r == ST_RD_RESP) || (state_r == ST_WR_WAIT)) begin
      wdog_r <= wdog_r + WDOG_W'(1);
    end
  end

  // Cache request channel: latched on grant, held stable until the next grant
  always_ff @(posedge clk) begin
    if (reset) begin
      reqcyc  <= 1'b0;
      req     <= {ADDR_W{1'b0}};
      reqdata <= {DATA_W{1'b0}};
      reqtag  <= {TAG_W{1'b0}};
    end else begin
      reqcyc <= (state_nxt_s == ST_RD_REQ) || (state_nxt_s == ST_WR_REQ);
      if (grant_wr_s) begin
        req     <= wr_req_addr;
        reqdata <= wr_req_data;
        reqtag  <= TAG_WR;
      end else if (grant_rd_s) begin
        req     <= rd_req_addr;
        reqdata <= {DATA_W{1'b0}};
        reqtag  <= TAG_RD;
      end
    end
  end

  // Requester-side completion pulses, load data capture and sticky abort flag
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_resp_valid <= 1'b0;
      rd_resp_data  <= {DATA_W{1'b0}};
      wr_done       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      rd_resp_valid <= rd_fire_s;
      wr_done       <= wr_fire_s;
      if (rd_fire_s) begin
        rd_resp_data <= resp;
      end
      if (abort_s) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter (watchdog limit set to 4 cycles).
module tb_dcache_port_arbiter;

  localparam logic [12:0] TAG_RD = 13'h1100;  // {1,0001,0,0000000}
  localparam logic [12:0] TAG_WR = 13'h0100;  // {0,0001,0,0000000}

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req_valid;
  logic [63:0] rd_req_addr;
  logic        rd_req_ready;
  logic        rd_resp_valid;
  logic [63:0] rd_resp_data;
  logic        wr_req_valid;
  logic [63:0] wr_req_addr;
  logic [63:0] wr_req_data;
  logic        wr_req_ready;
  logic        wr_done;
  logic        reqcyc;
  logic [63:0] req;
  logic [63:0] reqdata;
  logic [12:0] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic        respack;
  logic        writeack;
  logic        busy;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  dcache_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .TAG_W(13), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_ready(wr_req_ready), .wr_done(wr_done),
    .reqcyc(reqcyc), .req(req), .reqdata(reqdata), .reqtag(reqtag), .reqack(reqack),
    .respcyc(respcyc), .resp(resp), .respack(respack), .writeack(writeack),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL tb_time_limit: got running required finished");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd_req_valid = 1'b0; rd_req_addr = 64'd0;
    wr_req_valid = 1'b0; wr_req_addr = 64'd0; wr_req_data = 64'd0;
    reqack = 1'b0; respcyc = 1'b0; resp = 64'd0; writeack = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc();
    checks++;
    if ({busy, reqcyc, rd_resp_valid, wr_done, timeout_err, rd_req_ready, wr_req_ready, respack} !== 8'd0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 00000000",
               {busy, reqcyc, rd_resp_valid, wr_done, timeout_err, rd_req_ready, wr_req_ready, respack});
    end
    checks++;
    if ({req, reqdata, rd_resp_data, 3'b000, reqtag} !== 208'd0) begin
      failures++;
      $display("FAIL reset_regs: got req=%h reqdata=%h rdata=%h tag=%h required 0", req, reqdata, rd_resp_data, reqtag);
    end
  endtask

  task automatic test_read_only();
    rd_req_valid = 1'b1; rd_req_addr = 64'h1000;
    #2;
    checks++;
    if ({rd_req_ready, wr_req_ready} !== 2'b10) begin
      failures++; $display("FAIL rd_only_ready: got %b required 10", {rd_req_ready, wr_req_ready});
    end
    cyc();
    rd_req_valid = 1'b0;
    checks++;
    if (reqcyc !== 1'b1 || req !== 64'h1000 || reqtag !== TAG_RD || reqdata !== 64'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rd_only_req: got cyc=%b req=%h tag=%h data=%h busy=%b required 1 1000 %h 0 1",
               reqcyc, req, reqtag, reqdata, busy, TAG_RD);
    end
    reqack = 1'b1;
    cyc();
    reqack = 1'b0; respcyc = 1'b1; resp = 64'hDEAD;
    #2;
    checks++;
    if (respack !== 1'b1 || reqcyc !== 1'b0 || rd_resp_valid !== 1'b0) begin
      failures++; $display("FAIL rd_only_respack: got ack=%b cyc=%b rv=%b required 1 0 0", respack, reqcyc, rd_resp_valid);
    end
    cyc();
    respcyc = 1'b0;
    checks++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== 64'hDEAD || busy !== 1'b0) begin
      failures++; $display("FAIL rd_only_resp: got v=%b d=%h busy=%b required 1 dead 0", rd_resp_valid, rd_resp_data, busy);
    end
    cyc();
    checks++;
    if (rd_resp_valid !== 1'b0 || rd_resp_data !== 64'hDEAD) begin
      failures++; $display("FAIL rd_only_pulse: got v=%b d=%h required 0 dead", rd_resp_valid, rd_resp_data);
    end
  endtask

  task automatic test_contention();
    logic exp_wr;
    logic [63:0] exp_d;
    do_reset();
    cyc();
    for (int k = 0; k < 4; k++) begin
      exp_wr = (k % 2 == 0);  // WR, RD, WR, RD after reset
      rd_req_valid = 1'b1; rd_req_addr = 64'h3000 + 64'(k);
      wr_req_valid = 1'b1; wr_req_addr = 64'h2000 + 64'(k); wr_req_data = 64'h55 + 64'(k);
      #2;
      checks++;
      if ({rd_req_ready, wr_req_ready} !== {~exp_wr, exp_wr}) begin
        failures++; $display("FAIL contend_grant%0d: got rd/wr ready %b required %b", k, {rd_req_ready, wr_req_ready}, {~exp_wr, exp_wr});
      end
      cyc();
      if (exp_wr) wr_req_valid = 1'b0; else rd_req_valid = 1'b0;
      checks++;
      if (reqtag !== (exp_wr ? TAG_WR : TAG_RD) || req !== (exp_wr ? 64'h2000 + 64'(k) : 64'h3000 + 64'(k))) begin
        failures++; $display("FAIL contend_req%0d: got tag=%h req=%h", k, reqtag, req);
      end
      reqack = 1'b1;
      cyc();
      reqack = 1'b0;
      exp_d = 64'hC0DE0000 + 64'(k);
      if (exp_wr) writeack = 1'b1; else begin respcyc = 1'b1; resp = exp_d; end
      cyc();
      writeack = 1'b0; respcyc = 1'b0;
      checks++;
      if (exp_wr ? (wr_done !== 1'b1 || rd_resp_valid !== 1'b0)
                 : (rd_resp_valid !== 1'b1 || rd_resp_data !== exp_d || wr_done !== 1'b0)) begin
        failures++; $display("FAIL contend_done%0d: got wd=%b rv=%b rd=%h", k, wr_done, rd_resp_valid, rd_resp_data);
      end
    end
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reqack_stall();
    wr_req_valid = 1'b1; wr_req_addr = 64'hABCD_0000_1234_5678; wr_req_data = 64'h1122_3344_5566_7788;
    cyc();
    wr_req_valid = 1'b0; wr_req_addr = 64'd0; wr_req_data = 64'd0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (reqcyc !== 1'b1 || req !== 64'hABCD_0000_1234_5678 || reqdata !== 64'h1122_3344_5566_7788 || reqtag !== TAG_WR) begin
        failures++; $display("FAIL stall_hold%0d: got cyc=%b req=%h data=%h tag=%h", i, reqcyc, req, reqdata, reqtag);
      end
      cyc();
    end
    reqack = 1'b1;
    cyc();
    reqack = 1'b0;
    checks++;
    if (reqcyc !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL stall_release: got cyc=%b busy=%b required 0 1", reqcyc, busy);
    end
    writeack = 1'b1;
    cyc();
    writeack = 1'b0;
    cyc();
  endtask

  task automatic test_wr_coincident();
    wr_req_valid = 1'b1; wr_req_addr = 64'h4000; wr_req_data = 64'h99;
    cyc();
    wr_req_valid = 1'b0;
    reqack = 1'b1; writeack = 1'b1;
    cyc();
    reqack = 1'b0; writeack = 1'b0;
    checks++;
    if (wr_done !== 1'b1 || busy !== 1'b0 || reqcyc !== 1'b0) begin
      failures++; $display("FAIL wr_coincident: got done=%b busy=%b cyc=%b required 1 0 0", wr_done, busy, reqcyc);
    end
    cyc();
    checks++;
    if (wr_done !== 1'b0) begin
      failures++; $display("FAIL wr_coincident_pulse: got %b required 0", wr_done);
    end
  endtask

  // Transaction-level model: pending request per port, alternation on contention
  task automatic test_random();
    logic rd_pend, wr_pend, last_wr, exp_wr, co;
    logic [63:0] rd_a, wr_a, wr_d, exp_a, exp_data, rdat;
    int d;
    do_reset();
    cyc();
    rd_pend = 1'b0; wr_pend = 1'b0; last_wr = 1'b0;
    rd_a = 64'd0; wr_a = 64'd0; wr_d = 64'd0;
    for (int n = 0; n < 40; n++) begin
      if (!rd_pend && $urandom_range(0, 9) < 6) begin rd_pend = 1'b1; rd_a = {$urandom, $urandom}; end
      if (!wr_pend && $urandom_range(0, 9) < 6) begin wr_pend = 1'b1; wr_a = {$urandom, $urandom}; wr_d = {$urandom, $urandom}; end
      if (!rd_pend && !wr_pend) begin rd_pend = 1'b1; rd_a = {$urandom, $urandom}; end
      rd_req_valid = rd_pend; rd_req_addr = rd_a;
      wr_req_valid = wr_pend; wr_req_addr = wr_a; wr_req_data = wr_d;
      exp_wr   = wr_pend && (!rd_pend || !last_wr);
      exp_a    = exp_wr ? wr_a : rd_a;
      exp_data = exp_wr ? wr_d : 64'd0;
      #2;
      checks++;
      if ({rd_req_ready, wr_req_ready} !== {~exp_wr, exp_wr}) begin
        failures++; $display("FAIL rand_grant%0d: got rd/wr ready %b required %b", n, {rd_req_ready, wr_req_ready}, {~exp_wr, exp_wr});
      end
      cyc();
      last_wr = exp_wr;
      if (exp_wr) begin wr_pend = 1'b0; wr_req_valid = 1'b0; end
      else begin rd_pend = 1'b0; rd_req_valid = 1'b0; end
      checks++;
      if (reqcyc !== 1'b1 || req !== exp_a || reqdata !== exp_data || reqtag !== (exp_wr ? TAG_WR : TAG_RD)
          || rd_resp_valid !== 1'b0 || wr_done !== 1'b0) begin
        failures++; $display("FAIL rand_req%0d: got cyc=%b req=%h data=%h tag=%h rv=%b wd=%b required req=%h data=%h",
                             n, reqcyc, req, reqdata, reqtag, rd_resp_valid, wr_done, exp_a, exp_data);
      end
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        cyc();
        checks++;
        if (reqcyc !== 1'b1 || req !== exp_a || rd_req_ready !== 1'b0 || wr_req_ready !== 1'b0) begin
          failures++; $display("FAIL rand_hold%0d: got cyc=%b req=%h ready=%b%b", n, reqcyc, req, rd_req_ready, wr_req_ready);
        end
      end
      reqack = 1'b1;
      co = exp_wr && ($urandom_range(0, 3) == 0);
      writeack = co;
      cyc();
      reqack = 1'b0; writeack = 1'b0;
      if (co) begin
        checks++;
        if (wr_done !== 1'b1 || busy !== 1'b0 || reqcyc !== 1'b0) begin
          failures++; $display("FAIL rand_co%0d: got wd=%b busy=%b cyc=%b required 1 0 0", n, wr_done, busy, reqcyc);
        end
      end else begin
        d = $urandom_range(0, 2);
        for (int i = 0; i < d; i++) begin
          checks++;
          if (busy !== 1'b1 || reqcyc !== 1'b0 || rd_req_ready !== 1'b0 || wr_req_ready !== 1'b0) begin
            failures++; $display("FAIL rand_wait%0d: got busy=%b cyc=%b ready=%b%b", n, busy, reqcyc, rd_req_ready, wr_req_ready);
          end
          cyc();
        end
        rdat = {$urandom, $urandom};
        if (exp_wr) writeack = 1'b1;
        else begin respcyc = 1'b1; resp = rdat; end
        #2;
        checks++;
        if (respack !== !exp_wr) begin
          failures++; $display("FAIL rand_respack%0d: got %b required %b", n, respack, !exp_wr);
        end
        cyc();
        writeack = 1'b0; respcyc = 1'b0;
        checks++;
        if (busy !== 1'b0 || (exp_wr ? (wr_done !== 1'b1 || rd_resp_valid !== 1'b0)
                                     : (rd_resp_valid !== 1'b1 || rd_resp_data !== rdat || wr_done !== 1'b0))) begin
          failures++; $display("FAIL rand_done%0d: got busy=%b wd=%b rv=%b rd=%h required data %h",
                               n, busy, wr_done, rd_resp_valid, rd_resp_data, rdat);
        end
      end
    end
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    cyc();
  endtask

  task automatic test_last_cycle_completion();
    rd_req_valid = 1'b1; rd_req_addr = 64'h5000;
    cyc();
    rd_req_valid = 1'b0; reqack = 1'b1;
    cyc();
    reqack = 1'b0;
    cyc(); cyc(); cyc();  // three waiting cycles, now in the fourth
    respcyc = 1'b1; resp = 64'h0BAD_F00D;
    cyc();
    respcyc = 1'b0;
    checks++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== 64'h0BAD_F00D || timeout_err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL last_cycle_win: got rv=%b rd=%h terr=%b busy=%b required 1 0badf00d 0 0",
                           rd_resp_valid, rd_resp_data, timeout_err, busy);
    end
    cyc();
  endtask

  task automatic test_timeout();
    rd_req_valid = 1'b1; rd_req_addr = 64'h6000;
    cyc();
    rd_req_valid = 1'b0; reqack = 1'b1;
    cyc();
    reqack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1 || timeout_err !== 1'b0) begin
        failures++; $display("FAIL timeout_wait%0d: got busy=%b terr=%b required 1 0", i, busy, timeout_err);
      end
      cyc();
    end
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || rd_resp_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_abort: got busy=%b terr=%b rv=%b required 0 1 0", busy, timeout_err, rd_resp_valid);
    end
    respcyc = 1'b1; resp = 64'h7777;
    #2;
    checks++;
    if (respack !== 1'b0) begin
      failures++; $display("FAIL timeout_late_ack: got %b required 0", respack);
    end
    cyc();
    respcyc = 1'b0;
    checks++;
    if (rd_resp_valid !== 1'b0 || timeout_err !== 1'b1 || rd_resp_data === 64'h7777) begin
      failures++; $display("FAIL timeout_late_resp: got rv=%b terr=%b rd=%h", rd_resp_valid, timeout_err, rd_resp_data);
    end
  endtask

  task automatic test_reset_midwr();
    wr_req_valid = 1'b1; wr_req_addr = 64'h8000; wr_req_data = 64'h42;
    cyc();
    wr_req_valid = 1'b0; reqack = 1'b1;
    cyc();
    reqack = 1'b0;
    reset = 1'b1; writeack = 1'b1;
    cyc();
    reset = 1'b0; writeack = 1'b0;
    checks++;
    if (busy !== 1'b0 || reqcyc !== 1'b0 || wr_done !== 1'b0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL reset_midwr: got busy=%b cyc=%b wd=%b terr=%b required 0 0 0 0", busy, reqcyc, wr_done, timeout_err);
    end
    cyc();
    checks++;
    if (wr_done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_midwr_after: got wd=%b busy=%b required 0 0", wr_done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_read_only();
    test_contention();
    test_reqack_stall();
    test_wr_coincident();
    test_random();
    test_last_cycle_completion();
    test_timeout();
    test_reset_midwr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
